sec_timer_display: RTL and testbench

Minutes:seconds stopwatch stage that sits directly downstream of the clock divider. It consumes the divider's slow square-wave output (one rising edge per second) as a level signal in the fast `clk` domain, counts BCD MM:SS from 00:00 to 59:59 under start/stop and clear control, and time-multiplexes the four digits onto a common-anode 4-digit 7-segment display. The slow signal is never used as a clock; every flop runs on `clk`.

---
 rtl/sec_timer_display.sv | 238 +++++++++++++++++++++++
 tb/tb_sec_timer_display.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sec_timer_display.sv
// ----------------------------------------------------------------------------
// sec_timer_display
//
// MM:SS stopwatch (00:00 .. 59:59) with a 4-digit common-anode 7-segment
// multiplexer. The one-second input from the clock divider is treated as a
// level and edge-detected in the clk domain; it is never used as a clock.
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active low
//   slow_in    divider output level, one rising edge per second
//   btn_start  debounced level, each rising edge toggles run/stop
//   btn_clear  debounced level, a rising edge zeroes the count
//   sec_ones, sec_tens, min_ones, min_tens   BCD count digits
//   running    1 while counting
//   rollover   one-cycle pulse on the 59:59 -> 00:00 wrap
//   an         digit enables, active low
//   seg        segments {g,f,e,d,c,b,a}, active low
//
// Parameter:
//   REFRESH    clk cycles each digit stays lit (2 .. 2^20)
// ----------------------------------------------------------------------------
module sec_timer_display #(
    parameter int REFRESH = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       slow_in,
    input  logic       btn_start,
    input  logic       btn_clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       rollover,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH - 1);

    // ------------------------------------------------------------------
    // slow_in synchronizer and rising-edge detect
    // ------------------------------------------------------------------
    logic s1;
    logic s2;
    logic s_prev;
    logic tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s_prev <= 1'b0;
        end else begin
            s1     <= slow_in;
            s2     <= s1;
            s_prev <= s2;
        end
    end

    assign tick = s2 & ~s_prev;

    // ------------------------------------------------------------------
    // Button edge detect. Buttons are already synchronous, so the pulse is
    // formed combinationally and acts on the same edge the press is seen.
    // Bit 0 = start, bit 1 = clear.
    // ------------------------------------------------------------------
    logic [1:0] btn_in;
    logic [1:0] b_q;
    logic [1:0] btn_p;
    logic       start_p;
    logic       clear_p;

    assign btn_in = {btn_clear, btn_start};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_q <= 2'b00;
        end else begin
            b_q <= btn_in;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn_edge
            assign btn_p[gi] = btn_in[gi] & ~b_q[gi];
        end
    endgenerate

    assign start_p = btn_p[0];
    assign clear_p = btn_p[1];

    // ------------------------------------------------------------------
    // Run state: only start_p moves it, clear leaves it untouched
    // ------------------------------------------------------------------
    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } run_t;

    run_t run_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_state <= STOPPED;
        end else if (start_p) begin
            case (run_state)
                STOPPED: run_state <= RUNNING;
                default: run_state <= STOPPED;
            endcase
        end
    end

    assign running = (run_state == RUNNING);

    // ------------------------------------------------------------------
    // BCD counter. Clear wins over a coincident tick, so the tick is lost
    // and no rollover is flagged. Ticks while stopped are dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
            rollover <= 1'b0;
        end else begin
            rollover <= 1'b0;
            if (clear_p) begin
                sec_ones <= 4'd0;
                sec_tens <= 4'd0;
                min_ones <= 4'd0;
                min_tens <= 4'd0;
            end else if (tick && run_state == RUNNING) begin
                if (sec_ones == 4'd9) begin
                    sec_ones <= 4'd0;
                    if (sec_tens == 4'd5) begin
                        sec_tens <= 4'd0;
                        if (min_ones == 4'd9) begin
                            min_ones <= 4'd0;
                            if (min_tens == 4'd5) begin
                                min_tens <= 4'd0;
                                rollover <= 1'b1;
                            end else begin
                                min_tens <= min_tens + 4'd1;
                            end
                        end else begin
                            min_ones <= min_ones + 4'd1;
                        end
                    end else begin
                        sec_tens <= sec_tens + 4'd1;
                    end
                end else begin
                    sec_ones <= sec_ones + 4'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Refresh counter and digit index
    // ------------------------------------------------------------------
    logic [RW-1:0] ref_cnt;
    logic [1:0]    dig;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_cnt <= '0;
            dig     <= 2'd0;
        end else if (ref_cnt == REF_LAST) begin
            ref_cnt <= '0;
            dig     <= dig + 2'd1;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Digit select and segment decode. an and seg share one register
    // stage so the enabled digit always matches its segment pattern.
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    logic [3:0] digit_sel;
    logic [3:0] an_next;

    always_comb begin
        digit_sel = sec_ones;
        an_next   = 4'b1110;
        case (dig)
            2'd0: begin
                digit_sel = sec_ones;
                an_next   = 4'b1110;
            end
            2'd1: begin
                digit_sel = sec_tens;
                an_next   = 4'b1101;
            end
            2'd2: begin
                digit_sel = min_ones;
                an_next   = 4'b1011;
            end
            default: begin
                digit_sel = min_tens;
                an_next   = 4'b0111;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= 4'b1110;
            seg <= 7'b1000000;
        end else begin
            an  <= an_next;
            seg <= seg_decode(digit_sel);
        end
    end

endmodule

// File: tb/tb_sec_timer_display.sv
// ----------------------------------------------------------------------------
// tb_sec_timer_display
//
// Directed bench for sec_timer_display with REFRESH=4. Each test task drives
// its own stimulus and compares outputs against hand-computed values.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_sec_timer_display;

    logic       clk;
    logic       rst;
    logic       slow_in;
    logic       btn_start;
    logic       btn_clear;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       running;
    logic       rollover;
    logic [3:0] an;
    logic [6:0] seg;

    int total;
    int bad;

    sec_timer_display #(
        .REFRESH(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .slow_in  (slow_in),
        .btn_start(btn_start),
        .btn_clear(btn_clear),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .min_ones (min_ones),
        .min_tens (min_tens),
        .running  (running),
        .rollover (rollover),
        .an       (an),
        .seg      (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [15:0] cnt = {min_tens, min_ones, sec_tens, sec_ones};

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One second: after return, the resulting increment is visible.
    task automatic slow_pulse();
        slow_in = 1'b1;
        step();
        slow_in = 1'b0;
        step();
        step();
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) slow_pulse();
    endtask

    task automatic press_start();
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        step();
    endtask

    task automatic press_clear();
        btn_clear = 1'b1;
        step();
        btn_clear = 1'b0;
        step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        slow_in = 1'b0;
        btn_start = 1'b0;
        btn_clear = 1'b0;
        repeat (3) step();
        total++;
        if (cnt !== 16'h0000) begin bad++; $display("FAIL reset_count got=%h want=0000", cnt); end
        total++;
        if (running !== 1'b0 || rollover !== 1'b0) begin
            bad++; $display("FAIL reset_flags got running=%b rollover=%b want 0/0", running, rollover);
        end
        total++;
        if (an !== 4'b1110 || seg !== 7'b1000000) begin
            bad++; $display("FAIL reset_display got an=%b seg=%b want 1110/1000000", an, seg);
        end
        rst = 1'b1;
        step();
        $display("test_reset: count=%h an=%b seg=%b", cnt, an, seg);
    endtask

    task automatic test_first_ticks();
        logic [15:0] exp_cnt;
        press_start();
        total++;
        if (running !== 1'b1) begin bad++; $display("FAIL start_running got=%b want=1", running); end
        exp_cnt = 16'h0000;
        for (int p = 0; p < 3; p++) begin
            slow_in = 1'b1;
            step();                       // edge k: first sample of high
            step();                       // edge k+1: tick now high
            total++;
            if (cnt !== exp_cnt) begin
                bad++; $display("FAIL tick_early p=%0d got=%h want=%h", p, cnt, exp_cnt);
            end
            step();                       // edge k+2: count moves
            exp_cnt = exp_cnt + 16'h1;
            total++;
            if (cnt !== exp_cnt) begin
                bad++; $display("FAIL tick_latency p=%0d got=%h want=%h", p, cnt, exp_cnt);
            end
            repeat (2) step();
            slow_in = 1'b0;
            repeat (5) step();
        end
        total++;
        if (cnt !== 16'h0003) begin bad++; $display("FAIL first_ticks_final got=%h want=0003", cnt); end
        $display("test_first_ticks: count=%h running=%b", cnt, running);
    endtask

    task automatic test_full_wrap();
        press_clear();
        tick_n(3598);
        total++;
        if (cnt !== 16'h5958) begin bad++; $display("FAIL wrap_preload got=%h want=5958", cnt); end
        slow_pulse();
        total++;
        if (cnt !== 16'h5959 || rollover !== 1'b0) begin
            bad++; $display("FAIL wrap_5959 got=%h rollover=%b want=5959/0", cnt, rollover);
        end
        slow_pulse();
        total++;
        if (cnt !== 16'h0000 || rollover !== 1'b1) begin
            bad++; $display("FAIL wrap_0000 got=%h rollover=%b want=0000/1", cnt, rollover);
        end
        step();
        total++;
        if (rollover !== 1'b0) begin bad++; $display("FAIL rollover_width got=%b want=0", rollover); end
        $display("test_full_wrap: count=%h", cnt);
    endtask

    task automatic test_stop_hold();
        press_clear();
        tick_n(5);
        total++;
        if (cnt !== 16'h0005) begin bad++; $display("FAIL hold_preload got=%h want=0005", cnt); end
        btn_start = 1'b1;
        step();
        total++;
        if (running !== 1'b0) begin bad++; $display("FAIL hold_stop got=%b want=0", running); end
        repeat (19) step();
        total++;
        if (running !== 1'b0) begin bad++; $display("FAIL hold_single_toggle got=%b want=0", running); end
        btn_start = 1'b0;
        step();
        tick_n(5);
        total++;
        if (cnt !== 16'h0005 || running !== 1'b0) begin
            bad++; $display("FAIL hold_frozen got=%h running=%b want=0005/0", cnt, running);
        end
        press_start();
        total++;
        if (running !== 1'b1) begin bad++; $display("FAIL hold_resume got=%b want=1", running); end
        slow_pulse();
        total++;
        if (cnt !== 16'h0006) begin bad++; $display("FAIL hold_next got=%h want=0006", cnt); end
        $display("test_stop_hold: count=%h running=%b", cnt, running);
    endtask

    task automatic test_coincident();
        press_clear();
        tick_n(754);
        total++;
        if (cnt !== 16'h1234 || running !== 1'b1) begin
            bad++; $display("FAIL coinc_preload got=%h running=%b want=1234/1", cnt, running);
        end
        slow_in = 1'b1;
        step();                           // edge k
        slow_in = 1'b0;
        step();                           // edge k+1: tick high
        btn_start = 1'b1;
        btn_clear = 1'b1;
        step();                           // edge k+2: all three coincide
        btn_start = 1'b0;
        btn_clear = 1'b0;
        total++;
        if (cnt !== 16'h0000) begin bad++; $display("FAIL coinc_count got=%h want=0000", cnt); end
        total++;
        if (running !== 1'b0 || rollover !== 1'b0) begin
            bad++; $display("FAIL coinc_flags got running=%b rollover=%b want 0/0", running, rollover);
        end
        step();
        $display("test_coincident: count=%h running=%b", cnt, running);
    endtask

    task automatic test_display_scan();
        logic [3:0] an_exp  [4];
        logic [6:0] seg_exp [4];
        logic [3:0] prev;
        bit         found;
        int         idx;
        // 47:19 -> digits 9,1,7,4 in scan order
        an_exp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_exp = '{7'b0010000, 7'b1111001, 7'b1111000, 7'b0011001};
        press_clear();
        press_start();
        tick_n(2839);
        press_start();
        total++;
        if (cnt !== 16'h4719 || running !== 1'b0) begin
            bad++; $display("FAIL scan_preload got=%h running=%b want=4719/0", cnt, running);
        end
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            prev = an;
            step();
            if (an === 4'b1110 && prev !== 4'b1110) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL scan_align got an=%b want transition to 1110", an);
        end else begin
            for (int j = 0; j < 20; j++) begin
                idx = (j / 4) % 4;
                total++;
                if (an !== an_exp[idx] || seg !== seg_exp[idx]) begin
                    bad++;
                    $display("FAIL scan_cycle j=%0d got an=%b seg=%b want an=%b seg=%b",
                             j, an, seg, an_exp[idx], seg_exp[idx]);
                end
                step();
            end
        end
        $display("test_display_scan: count=%h aligned=%0d", cnt, found);
    endtask

    task automatic test_mid_reset();
        logic [3:0] prev;
        bit         found;
        press_clear();
        press_start();
        tick_n(1425);
        total++;
        if (cnt !== 16'h2345 || running !== 1'b1) begin
            bad++; $display("FAIL mrst_preload got=%h running=%b want=2345/1", cnt, running);
        end
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            prev = an;
            step();
            if (an === 4'b1011 && prev !== 4'b1011) found = 1'b1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL mrst_align got an=%b want 1011", an); end
        // assert reset between clock edges; no edge occurs before the checks
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (cnt !== 16'h0000 || running !== 1'b0 || rollover !== 1'b0) begin
            bad++; $display("FAIL mrst_async_count got=%h running=%b rollover=%b want=0000/0/0",
                            cnt, running, rollover);
        end
        total++;
        if (an !== 4'b1110 || seg !== 7'b1000000) begin
            bad++; $display("FAIL mrst_async_display got an=%b seg=%b want 1110/1000000", an, seg);
        end
        step();
        step();
        rst = 1'b1;
        step();
        tick_n(3);
        total++;
        if (cnt !== 16'h0000 || running !== 1'b0) begin
            bad++; $display("FAIL mrst_ignored got=%h running=%b want=0000/0", cnt, running);
        end
        press_start();
        slow_pulse();
        total++;
        if (cnt !== 16'h0001 || running !== 1'b1) begin
            bad++; $display("FAIL mrst_restart got=%h running=%b want=0001/1", cnt, running);
        end
        $display("test_mid_reset: count=%h running=%b", cnt, running);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_first_ticks();
        test_full_wrap();
        test_stop_hold();
        test_coincident();
        test_display_scan();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
